// File: rtl/dsp_xfer_scheduler.sv
// Frame scheduler for the Zynq<->DSP DPBRAM exchange.
// Issues a periodic write-frame/read-frame pair, owns the DSP handshake,
// times out a silent DSP and keeps frame/timeout/overrun statistics.
module dsp_xfer_scheduler #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned ERR_W       = 16,
   parameter int unsigned FAULT_LIMIT = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_period,
   input  logic [CNT_W-1:0] i_timeout,
   input  logic             i_fault_clr,
   input  logic             i_cnt_clr,
   output logic             o_wr_start,
   input  logic             i_wr_done,
   output logic             o_w_valid,
   input  logic             i_w_ready,
   input  logic             i_r_valid,
   output logic             o_rd_start,
   input  logic             i_rd_done,
   output logic             o_busy,
   output logic [2:0]       o_state,
   output logic [31:0]      o_frame_cnt,
   output logic [ERR_W-1:0] o_timeout_cnt,
   output logic [ERR_W-1:0] o_overrun_cnt,
   output logic             o_link_fault
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_START = 3'd1,
      WR_BUSY  = 3'd2,
      WR_HS    = 3'd3,
      RD_WAIT  = 3'd4,
      RD_START = 3'd5,
      RD_BUSY  = 3'd6,
      DONE     = 3'd7
   } state_t;

   localparam int unsigned CONS_W = $clog2(FAULT_LIMIT + 1);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  per_cnt;
   logic [CNT_W-1:0]  to_cnt;
   logic [CONS_W-1:0] consec;
   logic              per_run;
   logic              tick;
   logic              hs_state;
   logic              to_expire;
   logic              timeout_ev;
   logic              overrun_ev;

   // Compare with >= so a period/timeout lowered below the running count
   // takes effect on the next compare instead of waiting for a counter wrap.
   assign per_run   = i_en && (i_period != '0);
   assign tick      = per_run && (per_cnt >= i_period - CNT_W'(1));
   assign hs_state  = (state == WR_HS) || (state == RD_WAIT);
   assign to_expire = (i_timeout != '0) && (to_cnt >= i_timeout - CNT_W'(1));
   assign overrun_ev = tick && (state != IDLE);

   // Frame period counter: free-runs 0..period-1 while enabled, else held at 0
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)                per_cnt <= '0;
      else if (!per_run || tick) per_cnt <= '0;
      else                       per_cnt <= per_cnt + CNT_W'(1);
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state, timeout event and state-decoded outputs
   always_comb begin
      state_nxt  = state;
      timeout_ev = 1'b0;
      o_wr_start = 1'b0;
      o_rd_start = 1'b0;
      o_w_valid  = 1'b0;
      o_busy     = (state != IDLE);
      o_state    = state;
      case (state)
         IDLE:     if (tick && !o_link_fault) state_nxt = WR_START;
         WR_START: begin
            o_wr_start = 1'b1;
            state_nxt  = WR_BUSY;
         end
         WR_BUSY:  if (i_wr_done) state_nxt = WR_HS;
         WR_HS: begin
            o_w_valid = 1'b1;
            if (i_w_ready) state_nxt = RD_WAIT;
            else if (to_expire) begin
               state_nxt  = IDLE;
               timeout_ev = 1'b1;
            end
         end
         RD_WAIT: begin
            if (i_r_valid) state_nxt = RD_START;
            else if (to_expire) begin
               state_nxt  = IDLE;
               timeout_ev = 1'b1;
            end
         end
         RD_START: begin
            o_rd_start = 1'b1;
            state_nxt  = RD_BUSY;
         end
         RD_BUSY:  if (i_rd_done) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Handshake timeout counter: restarts on every state change, counts while waiting
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)                              to_cnt <= '0;
      else if (hs_state && state_nxt == state) to_cnt <= to_cnt + CNT_W'(1);
      else                                     to_cnt <= '0;
   end

   // Statistics counters; a clear pulse beats a simultaneous increment
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_frame_cnt   <= '0;
         o_timeout_cnt <= '0;
         o_overrun_cnt <= '0;
      end else if (i_cnt_clr) begin
         o_frame_cnt   <= '0;
         o_timeout_cnt <= '0;
         o_overrun_cnt <= '0;
      end else begin
         if (state == DONE) o_frame_cnt <= o_frame_cnt + 32'd1;
         if (timeout_ev && o_timeout_cnt != '1)
            o_timeout_cnt <= o_timeout_cnt + ERR_W'(1);
         if (overrun_ev && o_overrun_cnt != '1)
            o_overrun_cnt <= o_overrun_cnt + ERR_W'(1);
      end
   end

   // Consecutive-timeout tracking and sticky link fault; a timeout beats a clear
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         consec       <= '0;
         o_link_fault <= 1'b0;
      end else if (timeout_ev) begin
         if (consec != CONS_W'(FAULT_LIMIT)) consec <= consec + CONS_W'(1);
         if (consec >= CONS_W'(FAULT_LIMIT - 1)) o_link_fault <= 1'b1;
      end else if (i_fault_clr) begin
         consec       <= '0;
         o_link_fault <= 1'b0;
      end else if (state == DONE) begin
         consec <= '0;
      end
   end

endmodule

// File: tb/tb_dsp_xfer_scheduler.sv
// Self-checking bench for dsp_xfer_scheduler: DSP/handler responder,
// frame-count scoreboard and one task per scenario.
`timescale 1ns/1ps
module tb_dsp_xfer_scheduler;

   localparam int CNT_W       = 16;
   localparam int ERR_W       = 4;
   localparam int FAULT_LIMIT = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             en = 1'b0;
   logic [CNT_W-1:0] period = '0;
   logic [CNT_W-1:0] tmo = '0;
   logic             fault_clr = 1'b0;
   logic             cnt_clr = 1'b0;
   logic             wr_done = 1'b0;
   logic             w_ready = 1'b0;
   logic             r_valid = 1'b0;
   logic             rd_done = 1'b0;
   logic             wr_start, w_valid, rd_start, busy, link_fault;
   logic [2:0]       state;
   logic [31:0]      frame_cnt;
   logic [ERR_W-1:0] timeout_cnt, overrun_cnt;

   dsp_xfer_scheduler #(.CNT_W(CNT_W), .ERR_W(ERR_W), .FAULT_LIMIT(FAULT_LIMIT)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_period(period), .i_timeout(tmo),
      .i_fault_clr(fault_clr), .i_cnt_clr(cnt_clr), .o_wr_start(wr_start),
      .i_wr_done(wr_done), .o_w_valid(w_valid), .i_w_ready(w_ready),
      .i_r_valid(r_valid), .o_rd_start(rd_start), .i_rd_done(rd_done),
      .o_busy(busy), .o_state(state), .o_frame_cnt(frame_cnt),
      .o_timeout_cnt(timeout_cnt), .o_overrun_cnt(overrun_cnt),
      .o_link_fault(link_fault)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_starts = 0;
   int rd_starts = 0;
   int wv_cycles = 0;
   logic [31:0] model_frames = '0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;
   bit          done_seen = 1'b0;

   // responder configuration
   int wr_dly = 30, rd_dly = 30, wrdy_dly = 3, rval_dly = 5;
   bit wrdy_en = 1'b1, rval_en = 1'b1;
   int wr_left = 0, rd_left = 0, hs_n = 0, rw_n = 0;

   // DSP and DPBRAM-handler responder, drives at negedge
   initial begin
      forever begin
         @(negedge clk);
         wr_done = 1'b0; rd_done = 1'b0; w_ready = 1'b0; r_valid = 1'b0;
         if (wr_start) wr_left = wr_dly;
         else if (wr_left > 0) begin
            wr_left--;
            if (wr_left == 0) wr_done = 1'b1;
         end
         if (rd_start) rd_left = rd_dly;
         else if (rd_left > 0) begin
            rd_left--;
            if (rd_left == 0) rd_done = 1'b1;
         end
         if (w_valid) begin
            hs_n++;
            if (wrdy_en && hs_n == wrdy_dly + 1) w_ready = 1'b1;
         end else hs_n = 0;
         if (state == 3'd4) begin
            rw_n++;
            if (rval_en && rw_n == rval_dly) r_valid = 1'b1;
         end else rw_n = 0;
      end
   end

   // Monitor and frame-count scoreboard: compares o_frame_cnt the cycle after DONE
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (wr_start) wr_starts++;
         if (rd_start) rd_starts++;
         if (w_valid)  wv_cycles++;
         if (done_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame_sb: unexpected frame completion, frame_cnt=%0d", frame_cnt);
            end else begin
               exp_v = exp_q.pop_front();
               if (frame_cnt !== exp_v) begin
                  errors++;
                  $display("FAIL frame_sb: frame_cnt=%0d expected %0d", frame_cnt, exp_v);
               end
            end
         end
         done_seen = (state == 3'd7);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_start(input int max, output bit got);
      got = 1'b0;
      for (int i = 0; i < max && !got; i++) begin
         tick();
         if (wr_start) got = 1'b1;
      end
   endtask

   task automatic wait_idle(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         tick();
         if (!busy) ok = 1'b1;
      end
      tick();
   endtask

   task automatic clr_counts();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      model_frames = '0;
   endtask

   task automatic pulse_fault_clr();
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++;
         $display("FAIL reset_state: state=%0d busy=%0b expected 0/0", state, busy); end
      checks++; if ({wr_start, rd_start, w_valid, link_fault} !== 4'b0) begin errors++;
         $display("FAIL reset_strobes: got %b expected 0000", {wr_start, rd_start, w_valid, link_fault}); end
      checks++; if (frame_cnt !== 32'd0 || timeout_cnt !== '0 || overrun_cnt !== '0) begin errors++;
         $display("FAIL reset_counts: frame=%0d to=%0d ov=%0d expected 0", frame_cnt, timeout_cnt, overrun_cnt); end
      rst_n = 1'b1;
      repeat (3) tick();
      checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++;
         $display("FAIL reset_release: state=%0d busy=%0b expected 0/0", state, busy); end
   endtask

   task automatic test_normal();
      bit got, ok;
      int last;
      period = 16'd100; tmo = 16'd50;
      wr_dly = 30; rd_dly = 30; wrdy_en = 1'b1; wrdy_dly = 3; rval_en = 1'b1; rval_dly = 5;
      clr_counts();
      en = 1'b1;
      last = 0;
      for (int f = 0; f < 10; f++) begin
         wait_start(150, got);
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL normal_start: frame %0d no wr_start within 150 cycles", f);
            break;
         end
         model_frames++;
         exp_q.push_back(model_frames);
         if (f > 0) begin
            checks++;
            if (cyc - last != 100) begin errors++;
               $display("FAIL normal_period: start interval %0d expected 100", cyc - last); end
         end
         last = cyc;
      end
      en = 1'b0;
      wait_idle(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL normal_idle: busy=%0b expected 0", busy); end
      checks++; if (frame_cnt !== 32'd10 || exp_q.size() != 0) begin errors++;
         $display("FAIL normal_frames: frame_cnt=%0d pending=%0d expected 10/0", frame_cnt, exp_q.size()); end
      checks++; if (timeout_cnt !== '0 || overrun_cnt !== '0) begin errors++;
         $display("FAIL normal_errs: to=%0d ov=%0d expected 0/0", timeout_cnt, overrun_cnt); end
   endtask

   task automatic test_wr_timeout();
      bit got, ok;
      int base_wv, base_rd;
      period = 16'd100; tmo = 16'd20; wr_dly = 30; wrdy_en = 1'b0;
      clr_counts();
      base_wv = wv_cycles; base_rd = rd_starts;
      en = 1'b1;
      wait_start(150, got);
      en = 1'b0;
      checks++; if (!got) begin errors++; $display("FAIL wto_start: no wr_start within 150 cycles"); end
      wait_idle(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wto_idle: busy=%0b expected 0", busy); end
      checks++; if (wv_cycles - base_wv != 20) begin errors++;
         $display("FAIL wto_wvalid: w_valid high %0d cycles expected 20", wv_cycles - base_wv); end
      checks++; if (rd_starts != base_rd) begin errors++;
         $display("FAIL wto_rdstart: %0d rd_start pulses expected 0", rd_starts - base_rd); end
      checks++; if (timeout_cnt !== 4'd1 || link_fault !== 1'b0) begin errors++;
         $display("FAIL wto_count: to=%0d fault=%0b expected 1/0", timeout_cnt, link_fault); end
      wrdy_en = 1'b1;
   endtask

   task automatic test_fault();
      bit got, ok;
      int base_st;
      logic [ERR_W-1:0] base_ov;
      pulse_fault_clr();
      period = 16'd60; tmo = 16'd10; wr_dly = 30; wrdy_en = 1'b0;
      clr_counts();
      base_st = wr_starts;
      en = 1'b1;
      for (int i = 0; i < 400 && !link_fault; i++) tick();
      checks++; if (link_fault !== 1'b1) begin errors++; $display("FAIL fault_set: link_fault=%0b expected 1", link_fault); end
      checks++; if (wr_starts - base_st != 3 || timeout_cnt !== 4'd3) begin errors++;
         $display("FAIL fault_count: starts=%0d to=%0d expected 3/3", wr_starts - base_st, timeout_cnt); end
      base_st = wr_starts; base_ov = overrun_cnt;
      repeat (200) tick();
      checks++; if (wr_starts != base_st) begin errors++;
         $display("FAIL fault_block: %0d starts while faulted expected 0", wr_starts - base_st); end
      checks++; if (overrun_cnt !== base_ov || link_fault !== 1'b1) begin errors++;
         $display("FAIL fault_overrun: ov=%0d fault=%0b expected %0d/1", overrun_cnt, link_fault, base_ov); end
      wrdy_en = 1'b1; wrdy_dly = 2; rval_dly = 3; rd_dly = 10;
      pulse_fault_clr();
      checks++; if (link_fault !== 1'b0) begin errors++; $display("FAIL fault_clr: link_fault=%0b expected 0", link_fault); end
      wait_start(70, got);
      en = 1'b0;
      checks++; if (!got) begin errors++; $display("FAIL fault_resume: no wr_start within 70 cycles"); end
      if (got) begin
         model_frames++;
         exp_q.push_back(model_frames);
      end
      wait_idle(100, ok);
      checks++; if (!ok || frame_cnt !== 32'd1) begin errors++;
         $display("FAIL fault_frame: idle=%0b frame_cnt=%0d expected 1/1", ok, frame_cnt); end
   endtask

   task automatic test_overrun();
      bit got, ok;
      int last;
      period = 16'd10; tmo = 16'd50; wr_dly = 15; rd_dly = 2;
      wrdy_en = 1'b1; wrdy_dly = 0; rval_en = 1'b1; rval_dly = 1;
      clr_counts();
      en = 1'b1;
      last = 0;
      for (int f = 0; f < 4; f++) begin
         wait_start(40, got);
         checks++;
         if (!got) begin errors++; $display("FAIL ovr_start: frame %0d no wr_start", f); break; end
         model_frames++;
         exp_q.push_back(model_frames);
         if (f > 0) begin
            checks++;
            if (cyc - last != 30) begin errors++;
               $display("FAIL ovr_interval: interval %0d expected 30", cyc - last); end
         end
         last = cyc;
      end
      en = 1'b0;
      wait_idle(60, ok);
      checks++; if (!ok || overrun_cnt !== 4'd6) begin errors++;
         $display("FAIL ovr_count: idle=%0b ov=%0d expected 1/6", ok, overrun_cnt); end
   endtask

   task automatic test_boundary_hs();
      bit got, ok;
      int base_rd;
      period = 16'd100; tmo = 16'd20; wr_dly = 5; rd_dly = 5;
      wrdy_en = 1'b1; wrdy_dly = 19; rval_en = 1'b1; rval_dly = 20;
      clr_counts();
      base_rd = rd_starts;
      en = 1'b1;
      wait_start(150, got);
      en = 1'b0;
      checks++; if (!got) begin errors++; $display("FAIL bnd_start: no wr_start within 150 cycles"); end
      if (got) begin
         model_frames++;
         exp_q.push_back(model_frames);
      end
      wait_idle(100, ok);
      checks++; if (rd_starts - base_rd != 1 || timeout_cnt !== '0) begin errors++;
         $display("FAIL bnd_last_cycle: rd_starts=%0d to=%0d expected 1/0", rd_starts - base_rd, timeout_cnt); end
      checks++; if (frame_cnt !== 32'd1) begin errors++;
         $display("FAIL bnd_frame: frame_cnt=%0d expected 1", frame_cnt); end
   endtask

   task automatic test_period_zero();
      int base_st;
      period = '0;
      clr_counts();
      base_st = wr_starts;
      en = 1'b1;
      repeat (300) tick();
      en = 1'b0;
      checks++; if (wr_starts != base_st || overrun_cnt !== '0 || state !== 3'd0) begin errors++;
         $display("FAIL period_zero: starts=%0d ov=%0d state=%0d expected 0/0/0", wr_starts - base_st, overrun_cnt, state); end
   endtask

   task automatic test_saturation();
      bit ok;
      int base_st;
      period = 16'd3; tmo = 16'd50; wr_dly = 40; rd_dly = 2;
      wrdy_en = 1'b1; wrdy_dly = 0; rval_en = 1'b1; rval_dly = 1;
      clr_counts();
      en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (wr_start) begin
            model_frames++;
            exp_q.push_back(model_frames);
         end
      end
      en = 1'b0;
      wait_idle(100, ok);
      checks++; if (!ok || overrun_cnt !== 4'hF) begin errors++;
         $display("FAIL sat_overrun: idle=%0b ov=%0d expected 1/15", ok, overrun_cnt); end
      period = 16'd20; tmo = 16'd2; wr_dly = 2; wrdy_en = 1'b0;
      clr_counts();
      base_st = wr_starts;
      en = 1'b1;
      for (int i = 0; i < 1500 && (wr_starts - base_st) < 18; i++) begin
         tick();
         fault_clr = link_fault;
      end
      en = 1'b0;
      fault_clr = 1'b0;
      wait_idle(50, ok);
      checks++; if (wr_starts - base_st != 18 || timeout_cnt !== 4'hF) begin errors++;
         $display("FAIL sat_timeout: starts=%0d to=%0d expected 18/15", wr_starts - base_st, timeout_cnt); end
      pulse_fault_clr();
      wrdy_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      period = 16'd50; tmo = 16'd50; wr_dly = 5; rd_dly = 40;
      wrdy_en = 1'b1; wrdy_dly = 1; rval_en = 1'b1; rval_dly = 2;
      en = 1'b1;
      for (int i = 0; i < 200 && state !== 3'd6; i++) tick();
      checks++; if (state !== 3'd6) begin errors++; $display("FAIL rst_reach: state=%0d expected 6", state); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (state !== 3'd0 || busy !== 1'b0 || {wr_start, rd_start, w_valid, link_fault} !== 4'b0) begin errors++;
         $display("FAIL rst_mid_outputs: state=%0d busy=%0b strobes=%b expected 0", state, busy, {wr_start, rd_start, w_valid, link_fault}); end
      checks++; if (frame_cnt !== 32'd0 || timeout_cnt !== '0 || overrun_cnt !== '0) begin errors++;
         $display("FAIL rst_mid_counts: frame=%0d to=%0d ov=%0d expected 0", frame_cnt, timeout_cnt, overrun_cnt); end
      en = 1'b0;
      model_frames = '0;
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++;
         $display("FAIL rst_mid_release: state=%0d busy=%0b expected 0/0", state, busy); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_wr_timeout();
      test_fault();
      test_overrun();
      test_boundary_hs();
      test_period_zero();
      test_saturation();
      test_reset_mid();
      repeat (5) tick();
      checks++; if (exp_q.size() != 0) begin errors++;
         $display("FAIL sb_drain: %0d expected frames never completed", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
